// File: rtl/lock_pkg.sv
// Shared types and constants for the canal-lock sequencer and its countdown timer.
// LOCK_HOLD_EN (optional) adds a hold input that freezes the countdown.
package lock_pkg;

    localparam int TIMER_W = 10;

    localparam int unsigned DEF_PASS_SECONDS  = 300;
    localparam int unsigned DEF_FILL_SECONDS  = 420;
    localparam int unsigned DEF_DRAIN_SECONDS = 480;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ENTER,
        ST_SHIFT,
        ST_EXIT
    } state_e;

    // An up-bound boat enters from the low side, a down-bound boat from the high side.
    function automatic logic entry_high(input logic dir);
        return dir == DIR_DOWN;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Seconds countdown for the lock phases: load wins over tick, saturates at zero.
// With LOCK_HOLD_EN defined a hold input suppresses ticks.
module lock_timer
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
`ifdef LOCK_HOLD_EN
    input  logic               hold,
`endif
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    logic [TIMER_W-1:0] count_d, count_q;
    logic               tick_en;

`ifdef LOCK_HOLD_EN
    assign tick_en = tick && !hold;
`else
    assign tick_en = tick;
`endif

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick_en && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Canal-lock sequencer: arbitrates up/down requests and runs PREP/ENTER/SHIFT/EXIT on the timer.
// Optional hold port and countdown freeze when LOCK_HOLD_EN is defined.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned FILL_SECONDS  = DEF_FILL_SECONDS,
    parameter int unsigned DRAIN_SECONDS = DEF_DRAIN_SECONDS,
    parameter int unsigned PASS_SECONDS  = DEF_PASS_SECONDS
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         req_up,
    input  logic         req_down,
`ifdef LOCK_HOLD_EN
    input  logic         hold,
`endif
    output logic         grant_up,
    output logic         grant_down,
    output logic         gate_low_open,
    output logic         gate_high_open,
    output logic         fill_valve,
    output logic         drain_valve,
    output logic         busy,
    output logic         level_high,
    output logic [9:0]   seconds_left
);

    localparam logic [TIMER_W-1:0] FILL_V  = TIMER_W'(FILL_SECONDS);
    localparam logic [TIMER_W-1:0] DRAIN_V = TIMER_W'(DRAIN_SECONDS);
    localparam logic [TIMER_W-1:0] PASS_V  = TIMER_W'(PASS_SECONDS);

    state_e state_d, state_q;
    logic   dir_d, dir_q, level_d, level_q;
    logic   grant_up_d, grant_up_q, grant_down_d, grant_down_q;
    logic   gate_low_d, gate_low_q, gate_high_d, gate_high_q;
    logic   fill_d, fill_q, drain_d, drain_q, busy_d, busy_q;
    logic   take_up, load, timer_zero, hold_i, advance;
    logic [TIMER_W-1:0] load_val;

`ifdef LOCK_HOLD_EN
    assign hold_i = hold;
`else
    assign hold_i = 1'b0;
`endif

    lock_timer u_timer (
        .clk      (clk),
        .reset    (reset),
`ifdef LOCK_HOLD_EN
        .hold     (hold),
`endif
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .count    (seconds_left),
        .zero     (timer_zero)
    );

    assign advance = timer_zero && !hold_i;

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        level_d      = level_q;
        grant_up_d   = 1'b0;
        grant_down_d = 1'b0;
        take_up      = 1'b0;
        load         = 1'b0;
        load_val     = '0;
        case (state_q)
            ST_IDLE: if (req_up || req_down) begin
                // On a tie the side matching the current level wins, so service alternates.
                take_up      = req_up && (!req_down || !level_q);
                dir_d        = take_up ? DIR_UP : DIR_DOWN;
                grant_up_d   = take_up;
                grant_down_d = !take_up;
                load         = 1'b1;
                if (entry_high(dir_d) == level_q) begin
                    state_d  = ST_ENTER;
                    load_val = PASS_V;
                end else begin
                    state_d  = ST_PREP;
                    load_val = entry_high(dir_d) ? FILL_V : DRAIN_V;
                end
            end
            ST_PREP: if (advance) begin
                level_d  = !level_q;
                state_d  = ST_ENTER;
                load     = 1'b1;
                load_val = PASS_V;
            end
            ST_ENTER: if (advance) begin
                state_d  = ST_SHIFT;
                load     = 1'b1;
                load_val = (dir_q == DIR_UP) ? FILL_V : DRAIN_V;
            end
            ST_SHIFT: if (advance) begin
                level_d  = !level_q;
                state_d  = ST_EXIT;
                load     = 1'b1;
                load_val = PASS_V;
            end
            ST_EXIT: if (advance) begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs follow the next state so they are registered alongside it.
        gate_low_d  = (state_d == ST_ENTER && dir_d == DIR_UP)   || (state_d == ST_EXIT && dir_d == DIR_DOWN);
        gate_high_d = (state_d == ST_ENTER && dir_d == DIR_DOWN) || (state_d == ST_EXIT && dir_d == DIR_UP);
        fill_d      = (state_d == ST_PREP && dir_d == DIR_DOWN)  || (state_d == ST_SHIFT && dir_d == DIR_UP);
        drain_d     = (state_d == ST_PREP && dir_d == DIR_UP)    || (state_d == ST_SHIFT && dir_d == DIR_DOWN);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_UP;
            level_q      <= 1'b0;
            grant_up_q   <= 1'b0;
            grant_down_q <= 1'b0;
            gate_low_q   <= 1'b0;
            gate_high_q  <= 1'b0;
            fill_q       <= 1'b0;
            drain_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            level_q      <= level_d;
            grant_up_q   <= grant_up_d;
            grant_down_q <= grant_down_d;
            gate_low_q   <= gate_low_d;
            gate_high_q  <= gate_high_d;
            fill_q       <= fill_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
        end
    end

    assign grant_up       = grant_up_q;
    assign grant_down     = grant_down_q;
    assign gate_low_open  = gate_low_q;
    assign gate_high_open = gate_high_q;
    assign fill_valve     = fill_q;
    assign drain_valve    = drain_q;
    assign busy           = busy_q;
    assign level_high     = level_q;

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Canal-lock sequencer that owns the 10-bit seconds countdown timer and uses it to run the chamber through its timed phases: drain, fill, boat entry and boat exit. It arbitrates between an upstream request (boat at the low side) and a downstream request (boat at the high side). It drives gate and valve enables for the lock datapath and exposes the remaining seconds of the current phase.

## Interface
- `FILL_SECONDS`, default 420 — chamber fill time, 7 min.
- `DRAIN_SECONDS`, default 480 — chamber drain time, 8 min.
- `PASS_SECONDS`, default 300 — gate-open window for a boat to enter or exit, 5 min.
- All three must be in 0..1023.

- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-low: 0 resets.
- `tick` in 1 — one-cycle 1 Hz strobe; the timer decrements only on tick.
- `req_up` in 1 — boat waiting at the low side; level, held until granted.
- `req_down` in 1 — boat waiting at the high side; level, held until granted.
- `hold` in 1 — freeze the countdown; present only with `LOCK_HOLD_EN`.
- `grant_up` out 1 — one-cycle pulse when the up request is accepted.
- `grant_down` out 1 — one-cycle pulse when the down request is accepted.
- `gate_low_open` out 1 — low-side gate enable.
- `gate_high_open` out 1 — high-side gate enable.
- `fill_valve` out 1 — fill valve enable.
- `drain_valve` out 1 — drain valve enable.
- `busy` out 1 — state is not IDLE.
- `level_high` out 1 — chamber water level; 1 means high.
- `seconds_left` out 10 — current timer value.

## Operation
- States: IDLE, PREP, ENTER, SHIFT, EXIT.
- Reset values: state IDLE, `level_high` 0, `seconds_left` 0, all other outputs 0.
- The entry side is low for up and high for down.
- In IDLE, arbitration picks one request:
  - If only one request is asserted, it wins.
  - If both are asserted, the request whose entry side matches `level_high` wins. This makes service alternate, so neither side starves.
- On acceptance:
  - The winning grant pulses for 1 cycle.
  - Direction is latched.
  - Next state is ENTER if the level already matches the entry side, otherwise PREP.
- PREP: bring the water to the entry level.
  - Timer loads FILL_SECONDS if the entry side is high, else DRAIN_SECONDS.
  - The matching valve is on.
  - On timer zero, `level_high` toggles and the state goes to ENTER.
- ENTER: timer loads PASS_SECONDS; the entry-side gate is open. On zero, go to SHIFT.
- SHIFT: timer loads FILL_SECONDS for up or DRAIN_SECONDS for down. The matching valve is on. On zero, `level_high` toggles and the state goes to EXIT.
- EXIT: timer loads PASS_SECONDS; the exit-side gate is open. On zero, go to IDLE.
- Invariants, which must hold in every cycle:
  - Gates are never both open.
  - Valves are never both on.
  - No gate is open while any valve is on.
- Timer behaviour:
  - Loads on the state-entry edge.
  - Decrements on `tick` while nonzero.
  - Saturates at 0 and never wraps.
- Requests asserted outside IDLE are ignored until IDLE. A request dropped before acceptance produces no grant.
- A reset assertion mid-operation immediately forces all reset values. The environment is responsible for the chamber state after an abort.

## Timing
- All outputs are registered.
- Grant and state change occur on the same edge; the state's outputs are valid in the following cycle.
- Timed state duration is N ticks plus 1 clk: the tick that brings the timer to 0, then a transition on the next edge.
- A parameter value of 0 makes that state last exactly 1 clk with no tick needed.
- A `tick` coinciding with the load edge is not counted.
- With `req_up` held and the chamber low: cycle 0 acceptance, ENTER, SHIFT, EXIT, then IDLE after 2·PASS + FILL ticks plus 3 clk.

## Configuration
- `LOCK_HOLD_EN` defined:
  - The `hold` port exists.
  - While `hold`=1, ticks are ignored and the state is frozen; all outputs keep their values.
  - `hold` does not block IDLE arbitration.
- `LOCK_HOLD_EN` undefined: no `hold` port; the timer decrements on every tick.

## Structure
- Shared package `lock_pkg`:
  - State enum.
  - Direction constants UP/DOWN.
  - TIMER_W = 10.
  - Default seconds constants 300/420/480.
- One sub-module, `lock_timer`:
  - Inputs: load, load value, tick, optional hold.
  - Outputs: 10-bit count and a zero flag.
  - Asynchronous active-low reset.

## Test plan
Parameters FILL=4, DRAIN=5, PASS=3 unless stated.
- Reset, then `req_up` with the chamber low → `grant_up` 1 cycle, no PREP. Sequence ENTER(3 ticks) gate_low, SHIFT(4) fill, EXIT(3) gate_high, then IDLE with `level_high`=1.
- Chamber low, `req_down` → PREP with drain off and fill on for 4 ticks, then ENTER with gate_high, SHIFT drain for 5 ticks, EXIT gate_low, ending at `level_high`=0.
- Both requests asserted with the chamber high → `grant_down` first. Then `grant_up` while `req_up` is still held, with no starvation.
- PASS=0 → ENTER and EXIT each last 1 clk; `seconds_left` stays 0.
- `reset`=0 asserted mid-SHIFT with `seconds_left`=2 → all outputs 0 with no clock edge; `reset`=1 returns to IDLE.
- With `LOCK_HOLD_EN` defined: `hold`=1 for 10 ticks in SHIFT → `seconds_left` stays frozen and `fill_valve` stays on. After release, the remaining ticks complete.
